murax_jtag_driver: RTL and testbench
====================================

# murax_jtag_driver

Host-side JTAG master that drives the Murax debug port (`io_jtag_tck`, `io_jtag_tms`, `io_jtag_tdi`, `io_jtag_tdo`) from a simple command/response interface. It is the initiator end of the JTAG link, placed on-chip next to the SoC so that test benches and board-level loaders can reach the VexRiscv debug TAP without an external probe. It generates TCK from the main clock, walks the TAP state machine, shifts IR/DR data LSB first and returns the captured TDO bits.

## Interface
- `CLK_DIV`, 4: main-clock cycles per TCK half-period; must be ≥1.
- `DATA_W`, 64: maximum scan length and width of the data buses.
- `LEN_W`, 7: width of `io_cmd_len`; must satisfy 2^LEN_W > DATA_W.
- `io_mainClk` in 1: sole clock.
- `io_asyncResetn` in 1: asynchronous, active-low reset.
- `io_cmd_valid` in 1: command request.
- `io_cmd_ready` out 1: high only in IDLE.
- `io_cmd_kind` in 2: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = reserved (treated as error).
- `io_cmd_len` in LEN_W: scan length in bits, 1..DATA_W.
- `io_cmd_data` in DATA_W: TDI bits, bit 0 shifted first.
- `io_rsp_valid` out 1: one-cycle completion pulse.
- `io_rsp_error` out 1: qualifies `io_rsp_valid`; bad kind or length.
- `io_rsp_data` out DATA_W: captured TDO, held until the next completion.
- `io_busy` out 1: high from command accept to `io_rsp_valid`, inclusive.
- `io_jtag_tck` out 1: generated TCK.
- `io_jtag_tms` out 1: TMS.
- `io_jtag_tdi` out 1: TDI.
- `io_jtag_tdo` in 1: TDO from the target.

## Operation
- **Reset values:**
  - `tck`=0, `tms`=1, `tdi`=0.
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_error`=0, `rsp_data`=0, `busy`=0.
  - Internal `synced`=0.
- **Acceptance:** a command is accepted on the edge where `cmd_valid && cmd_ready`. Fields are registered at that edge; later input changes are ignored.
- **Error check:** kind 3, or a scan with len=0 or len>DATA_W, produces `rsp_valid`=1 and `rsp_error`=1 on the next cycle. There is no TCK activity and `rsp_data` is unchanged.
- **States:** IDLE → [RESETSEQ] → SELECT → SHIFT → EXIT → DONE → IDLE.
  - RESETSEQ runs for kind 0. It also runs for a scan whenever `synced`=0, in which case it is prepended to the scan.
  - Kind 0 goes from RESETSEQ straight to DONE.
- **TMS sequences (one entry per TCK):**
  - RESETSEQ: 1,1,1,1,1,0. Ends in Run-Test/Idle and sets `synced`=1.
  - SELECT for DR: 1,0,0. For IR: 1,1,0,0. Ends in Shift-xR.
  - SHIFT: N TCKs. TMS=0 for bits 0..N-2 and TMS=1 on bit N-1, which moves the TAP to Exit1. TDI = `cmd_data[i]` on shift bit i.
  - EXIT: 1,0, via Update to Run-Test/Idle.
- **TDI outside SHIFT:** 0.
- **TDO capture:** `rsp_data[i]` = TDO sampled on shift bit i. Bits ≥ N are 0. `rsp_error`=0.
- **TCK count per command:**
  - Reset: 6.
  - DR scan: N+5.
  - IR scan: N+6.
  - Add 6 to a scan when `synced`=0.
- **Async reset:** takes effect at any point, including mid-shift. All outputs return to their reset values immediately and `synced` is cleared.

## Timing
- **TCK period:** one TCK = CLK_DIV cycles low followed by CLK_DIV cycles high. TCK is low whenever the block is idle.
- **TMS/TDI update:** TMS and TDI change only on the cycle TCK goes low, i.e. the start of each TCK period. They are stable for the whole period.
- **TDO sampling:** TDO is sampled on the main-clock edge where TCK rises.
- **First TCK:** the low phase of the first TCK begins in the cycle after acceptance.
- **Completion:** `rsp_valid` is asserted exactly 2·CLK_DIV·T+1 cycles after the accepting edge, where T is the TCK count. TCK has already returned low by then.
- **Back-to-back:** `cmd_ready` rises in the cycle after `rsp_valid`. A command held on `cmd_valid` is accepted in that cycle, giving a minimum of one idle cycle between commands.
- **No backpressure:** the response is not backpressured; `rsp_valid` is a single-cycle pulse.

## Test plan
Bench uses a behavioural IEEE 1149.1 TAP model: 5-bit IR (capture 5'b00001), IDCODE DR = 0x10001FFF selected by IR 0x01, 1-bit BYPASS.

- **Reset then IR scan:** reset released, kind 0, then kind 1, len 5, data 0x01, CLK_DIV=2.
  - TMS seen at rising edges: 111110, then 1100, 00001, 10.
  - `rsp_data` = 0x01.
  - The second `rsp_valid` comes 4·11+1 = 45 cycles after its accept.
- **IDCODE read:** kind 2, len 32, data 0 → `rsp_data` = 0x10001FFF, 37 TCKs, `rsp_error`=0.
- **Scan before sync:** kind 2, len 32 with no prior kind 0 → 43 TCKs, the first 6 with TMS 111110; `rsp_data` = 0x10001FFF.
- **Bad commands:** kind 2 with len 0, kind 3, and len 65 → each gives `rsp_valid`=`rsp_error`=1 one cycle after accept, TCK never toggles, and `rsp_data` keeps its previous value.
- **Reset mid-shift:** `io_asyncResetn` low during the SHIFT of a 32-bit scan → TCK=0, TMS=1, `busy`=0 and `cmd_ready`=1 in the same cycle. The next scan is prepended with RESETSEQ.
- **Held command:** `cmd_valid` held high with two queued BYPASS scans (len 4, data 0xA) → second accept occurs one cycle after the first `rsp_valid`; `rsp_data` = 0x4 (the BYPASS bit delays the data by one position).

Source files
------------

// File: rtl/murax_jtag_driver.sv
// JTAG master for the Murax debug TAP.
// Turns single commands (TAP reset, IR scan, DR scan) into TCK/TMS/TDI
// activity and returns the TDO bits captured while shifting, LSB first.
// TCK is produced from the main clock: CLK_DIV cycles low, then CLK_DIV
// cycles high. TMS/TDI change only when TCK goes low, and TDO is sampled
// on the main-clock edge where TCK rises.
module murax_jtag_driver #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 7
) (
  input  logic              io_mainClk,
  input  logic              io_asyncResetn,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [1:0]        io_cmd_kind,
  input  logic [LEN_W-1:0]  io_cmd_len,
  input  logic [DATA_W-1:0] io_cmd_data,
  output logic              io_rsp_valid,
  output logic              io_rsp_error,
  output logic [DATA_W-1:0] io_rsp_data,
  output logic              io_busy,
  output logic              io_jtag_tck,
  output logic              io_jtag_tms,
  output logic              io_jtag_tdi,
  input  logic              io_jtag_tdo
);
  localparam int CW = $clog2(2*CLK_DIV) + 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RESETSEQ = 3'd1;
  localparam logic [2:0] S_SELECT   = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_EXIT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  localparam logic [1:0] K_RESET = 2'd0;
  localparam logic [1:0] K_IR    = 2'd1;
  localparam logic [1:0] K_BAD   = 2'd3;

  localparam logic [CW-1:0]    CNT_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(2*CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(5);
  localparam logic [LEN_W-1:0] SDR_LAST = LEN_W'(2);
  localparam logic [LEN_W-1:0] SIR_LAST = LEN_W'(3);

  logic [2:0]        state, nxt_state;
  logic [LEN_W-1:0]  step, nxt_step;
  logic [CW-1:0]     cnt;
  logic [1:0]        kind_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q, cap;
  logic              err_q, synced, set_sync;
  logic              nxt_tms, nxt_tdi;
  logic              cmd_bad, is_ir;
  logic [LEN_W-1:0]  sel_last, sh_last;

  assign io_cmd_ready = (state == S_IDLE);
  assign io_busy      = (state != S_IDLE);

  // A scan length of zero or beyond the data bus is rejected; kind 0 ignores len.
  assign cmd_bad = (io_cmd_kind == K_BAD) ||
                   ((io_cmd_kind != K_RESET) &&
                    ((io_cmd_len == '0) || (io_cmd_len > LEN_MAX)));

  assign is_ir    = (kind_q == K_IR);
  assign sel_last = is_ir ? SIR_LAST : SDR_LAST;
  assign sh_last  = len_q - ONE;

  // Next TAP-walk position and the TMS/TDI it needs, applied when a TCK period ends.
  always_comb begin
    nxt_state = state;
    nxt_step  = step + ONE;
    set_sync  = 1'b0;
    case (state)
      S_RESETSEQ: if (step == RST_LAST) begin
        set_sync  = 1'b1;
        nxt_step  = '0;
        nxt_state = (kind_q == K_RESET) ? S_DONE : S_SELECT;
      end
      S_SELECT: if (step == sel_last) begin
        nxt_step  = '0;
        nxt_state = S_SHIFT;
      end
      S_SHIFT: if (step == sh_last) begin
        nxt_step  = '0;
        nxt_state = S_EXIT;
      end
      S_EXIT: if (step == ONE) begin
        nxt_step  = '0;
        nxt_state = S_DONE;
      end
      default: nxt_step = step;
    endcase

    nxt_tms = io_jtag_tms;
    nxt_tdi = 1'b0;
    case (nxt_state)
      S_RESETSEQ: nxt_tms = (nxt_step != RST_LAST);
      S_SELECT:   nxt_tms = (nxt_step == '0) || (is_ir && (nxt_step == ONE));
      S_SHIFT: begin
        nxt_tms = (nxt_step == sh_last);
        nxt_tdi = data_q[nxt_step[IW-1:0]];
      end
      S_EXIT:     nxt_tms = (nxt_step == '0);
      default:    nxt_tms = io_jtag_tms;
    endcase
  end

  // Command acceptance, TCK generation, TDO capture and the completion pulse.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state        <= S_IDLE;
      step         <= '0;
      cnt          <= '0;
      kind_q       <= '0;
      len_q        <= '0;
      data_q       <= '0;
      cap          <= '0;
      err_q        <= 1'b0;
      synced       <= 1'b0;
      io_jtag_tck  <= 1'b0;
      io_jtag_tms  <= 1'b1;
      io_jtag_tdi  <= 1'b0;
      io_rsp_valid <= 1'b0;
      io_rsp_error <= 1'b0;
      io_rsp_data  <= '0;
    end else begin
      io_rsp_valid <= 1'b0;
      io_rsp_error <= 1'b0;
      case (state)
        S_IDLE: if (io_cmd_valid) begin
          kind_q      <= io_cmd_kind;
          len_q       <= io_cmd_len;
          data_q      <= io_cmd_data;
          cap         <= '0;
          step        <= '0;
          cnt         <= '0;
          io_jtag_tck <= 1'b0;
          io_jtag_tdi <= 1'b0;
          // First TMS of both RESETSEQ and SELECT is 1.
          io_jtag_tms <= 1'b1;
          err_q       <= cmd_bad;
          if (cmd_bad)
            state <= S_DONE;
          else if ((io_cmd_kind == K_RESET) || !synced)
            state <= S_RESETSEQ;
          else
            state <= S_SELECT;
        end
        S_RESETSEQ, S_SELECT, S_SHIFT, S_EXIT: begin
          if (cnt == CNT_RISE) begin
            io_jtag_tck <= 1'b1;
            cnt         <= cnt + CW'(1);
            if (state == S_SHIFT) cap[step[IW-1:0]] <= io_jtag_tdo;
          end else if (cnt == CNT_LAST) begin
            io_jtag_tck <= 1'b0;
            cnt         <= '0;
            state       <= nxt_state;
            step        <= nxt_step;
            io_jtag_tms <= nxt_tms;
            io_jtag_tdi <= nxt_tdi;
            if (set_sync) synced <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          io_rsp_valid <= 1'b1;
          io_rsp_error <= err_q;
          if (!err_q) io_rsp_data <= cap;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_murax_jtag_driver.sv
// Bench for murax_jtag_driver: behavioural 1149.1 TAP target (5-bit IR,
// IDCODE 0x10001FFF at IR 0x01, 1-bit BYPASS otherwise), a directed
// vector table, held/mid-shift-reset sequences and a randomized run
// scored against a command-level reference model.
module tb_murax_jtag_driver;
  localparam int C  = 2;
  localparam int DW = 64;
  localparam int LW = 7;
  localparam logic [63:0] IDCODE = 64'h10001FFF;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    kind = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] data = '0;
  logic          rsp_valid, rsp_error, busy;
  logic [DW-1:0] rsp_data;
  logic          tck, tms, tdi;
  logic          tdo = 1'b0;

  always #5 clk = ~clk;

  murax_jtag_driver #(.CLK_DIV(C), .DATA_W(DW), .LEN_W(LW)) dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
    .io_cmd_kind(kind), .io_cmd_len(len), .io_cmd_data(data),
    .io_rsp_valid(rsp_valid), .io_rsp_error(rsp_error), .io_rsp_data(rsp_data),
    .io_busy(busy), .io_jtag_tck(tck), .io_jtag_tms(tms), .io_jtag_tdi(tdi),
    .io_jtag_tdo(tdo)
  );

  // ---------------- TAP target model ----------------
  localparam int TLR=0, RTI=1, SDS=2, CDR=3, SHDR=4, E1DR=5, PDR=6, E2DR=7,
                 UDR=8, SIS=9, CIR=10, SHIR=11, E1IR=12, PIR=13, E2IR=14, UIR=15;
  int          tap_st = TLR;
  logic [4:0]  tap_ir = 5'd1, ir_sr = '0;
  logic [31:0] dr_sr = '0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDS  : RTI;
      SDS:  return m ? SIS  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDS  : RTI;
      SIS:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR:  tap_ir <= 5'd1;
      CDR:  dr_sr  <= (tap_ir == 5'd1) ? IDCODE[31:0] : 32'd0;
      SHDR: dr_sr  <= (tap_ir == 5'd1) ? {tdi, dr_sr[31:1]} : {31'd0, tdi};
      CIR:  ir_sr  <= 5'b00001;
      SHIR: ir_sr  <= {tdi, ir_sr[4:1]};
      UIR:  tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  logic tms_q[$];
  always @(posedge tck) tms_q.push_back(tms);

  // ---------------- checking ----------------
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_synced = 1'b0;
  logic [4:0]  m_ir = 5'd1;
  logic [63:0] m_prev = '0;
  logic        exp_tms[$];

  task automatic predict(input logic [1:0] k, input logic [6:0] l, input logic [63:0] d,
                         output logic err, output int t, output logic [63:0] ed);
    logic pre;
    logic [127:0] v, cap_val;
    int cap_len;
    exp_tms.delete();
    err = (k == 2'd3) || (k != 2'd0 && (l == 0 || l > 64));
    t = 0;
    ed = m_prev;
    if (err) return;
    pre = (k == 2'd0) || !m_synced;
    if (pre) begin
      m_ir = 5'd1;
      repeat (5) exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      t = 6;
    end
    m_synced = 1'b1;
    if (k == 2'd0) begin
      ed = '0;
      m_prev = '0;
      return;
    end
    exp_tms.push_back(1'b1);
    if (k == 2'd1) exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);
    exp_tms.push_back(1'b0);
    for (int i = 0; i < int'(l); i++) exp_tms.push_back(i == int'(l) - 1);
    exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);
    t += int'(l) + ((k == 2'd1) ? 6 : 5);
    if (k == 2'd1)          begin cap_len = 5;  cap_val = 128'd1; end
    else if (m_ir == 5'd1)  begin cap_len = 32; cap_val = {64'd0, IDCODE}; end
    else                    begin cap_len = 1;  cap_val = 128'd0; end
    v = cap_val | ({64'd0, d} << cap_len);
    ed = '0;
    for (int i = 0; i < int'(l); i++) ed[i] = v[i];
    if (k == 2'd1) m_ir = 5'((v >> l) & 128'h1F);
    m_prev = ed;
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [1:0] k, input logic [6:0] l, input logic [63:0] d);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1'b1; kind = k; len = l; data = d;
    while (!cmd_ready && g < 2000) begin @(negedge clk); g++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    tms_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    kind = 2'($urandom);
    len  = LW'($urandom);
    data = {$urandom, $urandom};
  endtask

  task automatic finish_cmd(input string nm, input int t, input logic err,
                            input logic [63:0] ed, input logic chk_data);
    int lat = 0;
    logic [127:0] a = '0, e = '0;
    while (!rsp_valid && lat < 4000) begin @(posedge clk); #1; lat++; end
    chk({nm, ".latency"}, lat, 2*C*t + 1);
    chk({nm, ".error"}, rsp_error, err);
    if (chk_data) chk({nm, ".data"}, rsp_data, ed);
    chk({nm, ".tcks"}, tms_q.size(), t);
    for (int i = 0; i < tms_q.size() && i < 128; i++) a[i] = tms_q[i];
    for (int i = 0; i < exp_tms.size() && i < 128; i++) e[i] = exp_tms[i];
    chk({nm, ".tms"}, a, e);
    chk({nm, ".busy_at_rsp"}, {busy, cmd_ready, tck}, 3'b100);
    @(posedge clk); #1;
    chk({nm, ".after"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [6:0]  len;
    logic [63:0] data;
    logic        err;
    logic        has_data;
    logic [63:0] rdata;
    int          tcks;
  } vec_t;
  vec_t tbl[7];

  logic        p_err;
  int          p_t;
  logic [63:0] p_d;

  initial begin
    tbl[0] = '{2'd0, 7'd0,  64'h0,  1'b0, 1'b0, 64'h0,  6};
    tbl[1] = '{2'd1, 7'd5,  64'h01, 1'b0, 1'b1, 64'h01, 11};
    tbl[2] = '{2'd2, 7'd32, 64'h0,  1'b0, 1'b1, IDCODE, 37};
    tbl[3] = '{2'd2, 7'd0,  64'h5,  1'b1, 1'b1, IDCODE, 0};
    tbl[4] = '{2'd3, 7'd5,  64'h1,  1'b1, 1'b1, IDCODE, 0};
    tbl[5] = '{2'd2, 7'd65, 64'h3,  1'b1, 1'b1, IDCODE, 0};
    tbl[6] = '{2'd1, 7'd5,  64'h1F, 1'b0, 1'b1, 64'h01, 11};

    // Power-on reset values.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.jtag", {tck, tms, tdi}, 3'b010);
    chk("reset.ctrl", {cmd_ready, busy, rsp_valid, rsp_error}, 4'b1000);
    chk("reset.data", rsp_data, 0);
    rst_n = 1'b1;

    // Scan before sync: RESETSEQ is prepended.
    predict(2'd2, 7'd32, 64'h0, p_err, p_t, p_d);
    issue(2'd2, 7'd32, 64'h0); scramble();
    finish_cmd("presync", 43, 1'b0, IDCODE, 1'b1);

    // Directed table.
    foreach (tbl[i]) begin
      predict(tbl[i].kind, tbl[i].len, tbl[i].data, p_err, p_t, p_d);
      issue(tbl[i].kind, tbl[i].len, tbl[i].data); scramble();
      finish_cmd($sformatf("vec%0d", i), tbl[i].tcks, tbl[i].err, tbl[i].rdata, tbl[i].has_data);
    end

    // Held command: two BYPASS scans back to back.
    predict(2'd2, 7'd4, 64'hA, p_err, p_t, p_d);
    issue(2'd2, 7'd4, 64'hA);
    finish_cmd("held1", 9, 1'b0, 64'h4, 1'b1);
    predict(2'd2, 7'd4, 64'hA, p_err, p_t, p_d);
    tms_q.delete();
    @(posedge clk); #1;
    chk("held.second_accept", {busy, cmd_ready}, 2'b10);
    scramble();
    finish_cmd("held2", 9, 1'b0, 64'h4, 1'b1);

    // Randomized commands against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [1:0] k;
      logic [6:0] l;
      logic [63:0] d;
      int r;
      r = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      if (r == 0)      begin k = 2'd0; l = 7'($urandom); end
      else if (r == 1) begin k = 2'd3; l = 7'($urandom_range(1, 64)); end
      else if (r <= 4) begin
        k = 2'd1;
        l = 7'($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 64'h1 : 64'h1F;
      end else begin
        k = 2'd2;
        case ($urandom_range(0, 7))
          0:       l = 7'd0;
          1:       l = 7'($urandom_range(65, 127));
          default: l = 7'($urandom_range(1, 64));
        endcase
      end
      predict(k, l, d, p_err, p_t, p_d);
      issue(k, l, d); scramble();
      finish_cmd($sformatf("rnd%0d", n), p_t, p_err, p_d, k != 2'd0);
    end

    // Asynchronous reset in the middle of a 32-bit DR shift.
    issue(2'd2, 7'd32, 64'h0); scramble();
    repeat (2*C*13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid.jtag", {tck, tms, tdi}, 3'b010);
    chk("rst_mid.ctrl", {busy, cmd_ready, rsp_valid}, 3'b010);
    chk("rst_mid.data", rsp_data, 0);
    m_synced = 1'b0;
    m_prev = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    predict(2'd2, 7'd32, 64'h0, p_err, p_t, p_d);
    issue(2'd2, 7'd32, 64'h0); scramble();
    finish_cmd("rst_resync", 43, 1'b0, IDCODE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
